// File: rtl/ula_seq_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ula_seq_ctrl_pkg
// Shared definitions for the sequenced ALU controller:
//   - register-file geometry (depth, width, index width)
//   - 3-bit opcode constants
//   - FSM state enum
//   - packed result record {carry, zero, data}
// ----------------------------------------------------------------------------
package ula_seq_ctrl_pkg;

    localparam int RF_DEPTH = 4;
    localparam int RF_WIDTH = 4;
    localparam int RF_AW    = 2;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_NOTA = 3'd5;
    localparam logic [2:0] OP_LDI  = 3'd6;
    localparam logic [2:0] OP_PASS = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WRITE = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

    typedef struct packed {
        logic                carry;
        logic                zero;
        logic [RF_WIDTH-1:0] data;
    } result_t;

endpackage : ula_seq_ctrl_pkg

// File: rtl/ula_seq_ctrl_core.sv
// ----------------------------------------------------------------------------
// ula_core
// Purely combinational ALU used by ula_seq_ctrl.
// Ports:
//   a_i, b_i   : operands (register-file width)
//   imm_i      : immediate, returned unchanged for LDI
//   op_i       : 3-bit opcode
//   data_o     : low bits of the result (wraps modulo 2^width)
//   carry_o    : ADD carry-out, SUB no-borrow (A >= B); 0 for all other ops
//   zero_o     : result data is all zeros
// ----------------------------------------------------------------------------
module ula_core
    import ula_seq_ctrl_pkg::*;
(
    input  logic [RF_WIDTH-1:0] a_i,
    input  logic [RF_WIDTH-1:0] b_i,
    input  logic [RF_WIDTH-1:0] imm_i,
    input  logic [2:0]          op_i,
    output logic [RF_WIDTH-1:0] data_o,
    output logic                carry_o,
    output logic                zero_o
);

    // One extra bit so the carry/borrow falls out of the add/subtract.
    logic [RF_WIDTH:0] sum_w;
    logic [RF_WIDTH:0] diff_w;

    assign sum_w  = {1'b0, a_i} + {1'b0, b_i};
    assign diff_w = {1'b0, a_i} - {1'b0, b_i};

    always_comb begin
        data_o  = '0;
        carry_o = 1'b0;
        case (op_i)
            OP_ADD: begin
                data_o  = sum_w[RF_WIDTH-1:0];
                carry_o = sum_w[RF_WIDTH];
            end
            OP_SUB: begin
                data_o  = diff_w[RF_WIDTH-1:0];
                // Top bit of the extended difference is the borrow; carry
                // reports its absence, i.e. A >= B.
                carry_o = ~diff_w[RF_WIDTH];
            end
            OP_AND:  data_o = a_i & b_i;
            OP_OR:   data_o = a_i | b_i;
            OP_XOR:  data_o = a_i ^ b_i;
            OP_NOTA: data_o = ~a_i;
            OP_LDI:  data_o = imm_i;
            OP_PASS: data_o = a_i;
            default: data_o = '0;
        endcase
    end

    assign zero_o = (data_o == '0);

endmodule : ula_core

// File: rtl/ula_seq_ctrl.sv
// ----------------------------------------------------------------------------
// ula_seq_ctrl
// Strictly serialized single-command ALU sequencer with a 4x4 register file.
// A command runs IDLE -> FETCH -> EXEC -> WRITE -> RESP; the next command is
// only accepted once the response has been consumed and the FSM is back in
// IDLE, so a command always sees every earlier write.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready : command handshake (ready only in IDLE)
//   cmd_op, cmd_ra, cmd_rb, cmd_rd, cmd_imm : command fields, captured on accept
//   rsp_valid/rsp_ready : response handshake
//   rsp_data, rsp_carry, rsp_zero : result register contents
//   busy                : FSM is not in IDLE
//   dbg_addr/dbg_data   : combinational register-file read port
// ----------------------------------------------------------------------------
module ula_seq_ctrl
    import ula_seq_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [2:0]          cmd_op,
    input  logic [RF_AW-1:0]    cmd_ra,
    input  logic [RF_AW-1:0]    cmd_rb,
    input  logic [RF_AW-1:0]    cmd_rd,
    input  logic [RF_WIDTH-1:0] cmd_imm,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [RF_WIDTH-1:0] rsp_data,
    output logic                rsp_carry,
    output logic                rsp_zero,
    output logic                busy,
    input  logic [RF_AW-1:0]    dbg_addr,
    output logic [RF_WIDTH-1:0] dbg_data
);

    state_e              state_q;
    logic [RF_WIDTH-1:0] rf_q [RF_DEPTH];
    logic [RF_WIDTH-1:0] a_q;
    logic [RF_WIDTH-1:0] b_q;
    result_t             res_q;
    logic                rsp_valid_q;

    // Captured command fields; later changes on the cmd_* inputs are ignored.
    logic [2:0]          op_q;
    logic [RF_AW-1:0]    ra_q;
    logic [RF_AW-1:0]    rb_q;
    logic [RF_AW-1:0]    rd_q;
    logic [RF_WIDTH-1:0] imm_q;

    logic [RF_WIDTH-1:0] alu_data;
    logic                alu_carry;
    logic                alu_zero;

    ula_core u_core (
        .a_i     (a_q),
        .b_i     (b_q),
        .imm_i   (imm_q),
        .op_i    (op_q),
        .data_o  (alu_data),
        .carry_o (alu_carry),
        .zero_o  (alu_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rf_q        <= '{default: '0};
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            rsp_valid_q <= 1'b0;
            op_q        <= '0;
            ra_q        <= '0;
            rb_q        <= '0;
            rd_q        <= '0;
            imm_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q    <= cmd_op;
                        ra_q    <= cmd_ra;
                        rb_q    <= cmd_rb;
                        rd_q    <= cmd_rd;
                        imm_q   <= cmd_imm;
                        state_q <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    a_q     <= rf_q[ra_q];
                    b_q     <= rf_q[rb_q];
                    state_q <= ST_EXEC;
                end
                ST_EXEC: begin
                    res_q   <= '{carry: alu_carry, zero: alu_zero, data: alu_data};
                    state_q <= ST_WRITE;
                end
                ST_WRITE: begin
                    rf_q[rd_q] <= res_q.data;
                    state_q    <= ST_RESP;
                end
                ST_RESP: begin
                    // The first RESP cycle raises rsp_valid; the FSM only
                    // leaves once a presented response is taken, so an early
                    // rsp_ready cannot drop a result.
                    if (rsp_valid_q && rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end else begin
                        rsp_valid_q <= 1'b1;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = res_q.data;
    assign rsp_carry = res_q.carry;
    assign rsp_zero  = res_q.zero;
    assign dbg_data  = rf_q[dbg_addr];

endmodule : ula_seq_ctrl

// File: tb/tb_ula_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ula_seq_ctrl
// Directed-vector bench for ula_seq_ctrl with hand-computed expected values.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// at the same point, away from the edge.
// ----------------------------------------------------------------------------
module tb_ula_seq_ctrl;

    localparam logic [2:0] ADD  = 3'd0;
    localparam logic [2:0] SUB  = 3'd1;
    localparam logic [2:0] AND_ = 3'd2;
    localparam logic [2:0] OR_  = 3'd3;
    localparam logic [2:0] XOR_ = 3'd4;
    localparam logic [2:0] NOTA = 3'd5;
    localparam logic [2:0] LDI  = 3'd6;
    localparam logic [2:0] PASS = 3'd7;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [1:0] cmd_ra;
    logic [1:0] cmd_rb;
    logic [1:0] cmd_rd;
    logic [3:0] cmd_imm;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_data;
    logic       rsp_carry;
    logic       rsp_zero;
    logic       busy;
    logic [1:0] dbg_addr;
    logic [3:0] dbg_data;

    int errors = 0;
    int checks = 0;

    ula_seq_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_ra    (cmd_ra),
        .cmd_rb    (cmd_rb),
        .cmd_rd    (cmd_rd),
        .cmd_imm   (cmd_imm),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_carry (rsp_carry),
        .rsp_zero  (rsp_zero),
        .busy      (busy),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one command from IDLE through its response handshake, checking
    // latency, the register-file write and the response fields.
    task automatic do_cmd(input string tag, input logic [2:0] op,
                          input logic [1:0] ra, input logic [1:0] rb,
                          input logic [1:0] rd, input logic [3:0] imm,
                          input logic [3:0] ed, input logic ec, input logic ez);
        chk({tag, ".ready"}, cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_ra    = ra;
        cmd_rb    = rb;
        cmd_rd    = rd;
        cmd_imm   = imm;
        dbg_addr  = rd;
        step();                              // accept edge N
        cmd_valid = 1'b0;
        cmd_op    = ~op;                     // must be ignored after capture
        cmd_ra    = ~ra;
        cmd_rb    = ~rb;
        cmd_rd    = ~rd;
        cmd_imm   = ~imm;
        chk({tag, ".busy"}, busy, 1'b1);
        step();
        step();                              // after N+2
        chk({tag, ".vld_n2"}, rsp_valid, 1'b0);
        step();                              // after N+3: rf written
        chk({tag, ".rf"}, dbg_data, ed);
        chk({tag, ".vld_n3"}, rsp_valid, 1'b0);
        step();                              // after N+4: response
        chk({tag, ".vld_n4"}, rsp_valid, 1'b1);
        chk({tag, ".data"}, rsp_data, ed);
        chk({tag, ".carry"}, rsp_carry, ec);
        chk({tag, ".zero"}, rsp_zero, ez);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk({tag, ".vld_done"}, rsp_valid, 1'b0);
        chk({tag, ".idle"}, cmd_ready, 1'b1);
        $display("txn %s: op=%0d ra=%0d rb=%0d rd=%0d imm=%0d -> data=%0d carry=%0d zero=%0d",
                 tag, op, ra, rb, rd, imm, rsp_data, rsp_carry, rsp_zero);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_ra    = '0;
        cmd_rb    = '0;
        cmd_rd    = '0;
        cmd_imm   = '0;
        rsp_ready = 1'b0;
        dbg_addr  = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        chk("rst.valid", rsp_valid, 1'b0);
        chk("rst.data",  rsp_data,  4'd0);
        chk("rst.carry", rsp_carry, 1'b0);
        chk("rst.zero",  rsp_zero,  1'b0);
        chk("rst.busy",  busy,      1'b0);
        chk("rst.ready", cmd_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1;
            chk("rst.rf", dbg_data, 4'd0);
        end
        $display("txn reset: checked idle outputs and cleared register file");

        // rf: {0,0,0,0}
        do_cmd("ldi9",  LDI,  2'd0, 2'd0, 2'd2, 4'd9,  4'd9,  1'b0, 1'b0);
        do_cmd("ldi12", LDI,  2'd0, 2'd0, 2'd1, 4'd12, 4'd12, 1'b0, 1'b0);
        // 12 + 9 = 21 -> 5, carry
        do_cmd("add",   ADD,  2'd1, 2'd2, 2'd3, 4'd0,  4'd5,  1'b1, 1'b0);
        // 9 - 12 = -3 -> 13, borrow
        do_cmd("sub",   SUB,  2'd2, 2'd1, 2'd0, 4'd0,  4'd13, 1'b0, 1'b0);
        do_cmd("ldi6",  LDI,  2'd0, 2'd0, 2'd0, 4'd6,  4'd6,  1'b0, 1'b0);
        do_cmd("xor0",  XOR_, 2'd0, 2'd0, 2'd0, 4'd0,  4'd0,  1'b0, 1'b1);
        // rf: {0,12,9,5}
        do_cmd("and",   AND_, 2'd1, 2'd2, 2'd3, 4'd0,  4'd8,  1'b0, 1'b0);
        do_cmd("or",    OR_,  2'd1, 2'd2, 2'd3, 4'd0,  4'd13, 1'b0, 1'b0);
        do_cmd("nota",  NOTA, 2'd3, 2'd0, 2'd0, 4'd0,  4'd2,  1'b0, 1'b0);
        // equal operands: no borrow, zero result
        do_cmd("subeq", SUB,  2'd1, 2'd1, 2'd2, 4'd0,  4'd0,  1'b1, 1'b1);
        // ra == rb == rd: 12 + 12 = 24 -> 8, carry
        do_cmd("addself", ADD, 2'd1, 2'd1, 2'd1, 4'd0, 4'd8,  1'b1, 1'b0);
        do_cmd("ldi7",  LDI,  2'd0, 2'd0, 2'd1, 4'd7,  4'd7,  1'b0, 1'b0);
        do_cmd("pass",  PASS, 2'd1, 2'd0, 2'd2, 4'd0,  4'd7,  1'b0, 1'b0);
        // rf: {2,7,7,13}

        // Response stall with a competing command held on the input
        cmd_valid = 1'b1;
        cmd_op    = LDI;
        cmd_rd    = 2'd3;
        cmd_imm   = 4'd3;
        step();
        cmd_valid = 1'b0;
        repeat (4) step();
        chk("stall.vld", rsp_valid, 1'b1);
        cmd_valid = 1'b1;
        cmd_op    = LDI;
        cmd_rd    = 2'd0;
        cmd_imm   = 4'd15;
        dbg_addr  = 2'd0;
        for (int i = 0; i < 5; i++) begin
            chk("stall.ready", cmd_ready, 1'b0);
            chk("stall.vld_hold", rsp_valid, 1'b1);
            chk("stall.data", rsp_data, 4'd3);
            chk("stall.carry", rsp_carry, 1'b0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("stall.rel_ready", cmd_ready, 1'b1);
        chk("stall.rf0_kept", dbg_data, 4'd2);
        step();
        cmd_valid = 1'b0;
        chk("stall.accept", busy, 1'b1);
        repeat (3) step();
        chk("stall.rf0_new", dbg_data, 4'd15);
        step();
        chk("stall.vld2", rsp_valid, 1'b1);
        chk("stall.data2", rsp_data, 4'd15);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        $display("txn stall: held 5 cycles, next command accepted after release");

        // Reset during EXEC of ADD rd=1 with rf1=4
        do_cmd("ldi4",  LDI,  2'd0, 2'd0, 2'd1, 4'd4,  4'd4,  1'b0, 1'b0);
        cmd_valid = 1'b1;
        cmd_op    = ADD;
        cmd_ra    = 2'd1;
        cmd_rb    = 2'd1;
        cmd_rd    = 2'd1;
        dbg_addr  = 2'd1;
        step();                              // accept
        cmd_valid = 1'b0;
        step();                              // now in EXEC
        chk("rstmid.busy_pre", busy, 1'b1);
        reset = 1'b1;
        #1;
        chk("rstmid.rf1_async", dbg_data, 4'd0);
        chk("rstmid.ready_async", cmd_ready, 1'b1);
        step();
        reset = 1'b0;
        repeat (5) begin
            step();
            chk("rstmid.valid", rsp_valid, 1'b0);
        end
        chk("rstmid.rf1", dbg_data, 4'd0);
        chk("rstmid.busy", busy, 1'b0);
        chk("rstmid.ready", cmd_ready, 1'b1);
        $display("txn reset_mid: command aborted, rf1=%0d", dbg_data);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_ula_seq_ctrl
